// File: rtl/button_pkg.sv
// Shared types and constants for the switch front end: button ids and the
// lowest-index priority helper used when several releases land together.
package button_pkg;

    localparam int NUM_BUTTONS = 4;

    typedef logic [1:0] button_id_t;

    localparam button_id_t BTN_1 = 2'd0;
    localparam button_id_t BTN_2 = 2'd1;
    localparam button_id_t BTN_3 = 2'd2;
    localparam button_id_t BTN_4 = 2'd3;

    function automatic button_id_t lowest_index(input logic [NUM_BUTTONS-1:0] req);
        button_id_t id;
        id = BTN_1;
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (req[i]) id = button_id_t'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// One switch: 2-flop synchroniser followed by a stability counter; the level
// only moves after DEBOUNCE_CNT consecutive samples that disagree with it.
module debounce_filter #(
    parameter int DEBOUNCE_CNT = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Raw,
    output logic o_Level,
    output logic o_Fall
);

    localparam int CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] count;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sync_1  <= 1'b0;
            sync_2  <= 1'b0;
            count   <= '0;
            o_Level <= 1'b0;
            o_Fall  <= 1'b0;
        end else begin
            sync_1 <= i_Raw;
            sync_2 <= sync_1;
            o_Fall <= 1'b0;
            if (sync_2 == o_Level) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                // o_Fall pulses in the same cycle the level is first seen low
                count   <= '0;
                o_Level <= sync_2;
                o_Fall  <= o_Level;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_event_conditioner.sv
// Debounces four game switches and queues their releases as button-id events.
// Optional feature macro COMBO_RESTART_EN: Switch_1+Switch_2 held = restart request.
module button_event_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 250000,
    parameter int QUEUE_DEPTH  = 2
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic [NUM_BUTTONS-1:0] i_Switch,
    output logic [NUM_BUTTONS-1:0] o_Switch,
    output logic                   o_Event_Valid,
    output button_id_t             o_Event_Id,
    input  logic                   i_Event_Ready,
    output logic                   o_Overflow,
    output logic                   o_Restart
);

    logic [NUM_BUTTONS-1:0] level;
    logic [NUM_BUTTONS-1:0] fall;
    logic [NUM_BUTTONS-1:0] suppress;
    logic [NUM_BUTTONS-1:0] release_req;

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_debounce
        debounce_filter #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_debounce (
            .i_Clk  (i_Clk),
            .i_Rst  (i_Rst),
            .i_Raw  (i_Switch[g]),
            .o_Level(level[g]),
            .o_Fall (fall[g])
        );
    end

    assign o_Switch = level;

`ifdef COMBO_RESTART_EN
    logic       restart_q;
    logic [1:0] level_d;
    logic [1:0] restart_seen;

    // restart_seen[i]: restart was active at some point since switch i was pressed
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            restart_q    <= 1'b0;
            level_d      <= 2'b00;
            restart_seen <= 2'b00;
        end else begin
            restart_q <= level[0] & level[1];
            level_d   <= level[1:0];
            for (int i = 0; i < 2; i++) begin
                if (level[i] & ~level_d[i])
                    restart_seen[i] <= 1'b0;
                else if (restart_q)
                    restart_seen[i] <= 1'b1;
            end
        end
    end

    assign suppress  = {{(NUM_BUTTONS-2){1'b0}}, restart_seen | {2{restart_q}}};
    assign o_Restart = restart_q;
`else
    assign suppress  = '0;
    assign o_Restart = 1'b0;
`endif

    assign release_req = fall & ~suppress;

    logic       push_q;
    button_id_t push_id_q;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            push_q    <= 1'b0;
            push_id_q <= BTN_1;
        end else begin
            push_q    <= |release_req;
            push_id_q <= lowest_index(release_req);
        end
    end

    button_id_t q_id [2];
    logic [1:0] q_count;
    logic       overflow_q;
    logic       pop;
    logic       full;

    assign pop  = (q_count != 2'd0) & i_Event_Ready;
    assign full = (q_count == 2'(QUEUE_DEPTH));

    // Head lives in q_id[0]; a pop shifts entry 1 down so the id only moves on acceptance
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            q_id       <= '{default: BTN_1};
            q_count    <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            case ({pop, push_q})
                2'b11: begin
                    if (q_count == 2'd1) begin
                        q_id[0] <= push_id_q;
                    end else begin
                        q_id[0] <= q_id[1];
                        q_id[1] <= push_id_q;
                    end
                end
                2'b10: begin
                    q_id[0] <= q_id[1];
                    q_count <= q_count - 1'b1;
                end
                2'b01: begin
                    if (full) begin
                        overflow_q <= 1'b1;
                    end else begin
                        q_id[q_count[0]] <= push_id_q;
                        q_count          <= q_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_Event_Valid = (q_count != 2'd0);
    assign o_Event_Id    = q_id[0];
    assign o_Overflow    = overflow_q;

endmodule
